// File: rtl/layer_sched.sv
// layer_sched: shares one 8-bit MAC across N_OUT neurons of N_IN inputs, adding bias and ReLU.
// Optional LAYER_SCHED_SAT_EN: 16-bit products, 20-bit accumulator, saturation to [-128,127] before ReLU.
module layer_sched #(
  parameter int N_IN  = 10,
  parameter int N_OUT = 16,
  parameter int AW    = 4,
  parameter int WW    = 8,
  parameter int OW    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        act_addr,
  input  logic signed [7:0]    act_data,
  output logic [WW-1:0]        w_addr,
  input  logic signed [7:0]    w_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OW-1:0]        out_idx,
  output logic [7:0]           out_data
);

`ifdef LAYER_SCHED_SAT_EN
  localparam int ACC_W = 20;
`else
  localparam int ACC_W = 8;
`endif

  localparam int KW = $clog2(N_IN + 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_IN);
  localparam logic [OW-1:0] N_LAST = OW'(N_OUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [OW-1:0]            n_q, n_d;
  logic [KW-1:0]            k_q, k_d;
  logic [AW-1:0]            act_addr_q, act_addr_d;
  logic [WW-1:0]            w_addr_q, w_addr_d;
  logic                     tag_vld_q, tag_vld_d;
  logic [KW-1:0]            tag_k_q, tag_k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [7:0]               out_data_q, out_data_d;
  logic [OW-1:0]            out_idx_q, out_idx_d;

  logic signed [ACC_W-1:0]  prod, bias;
  logic [7:0]               acc8;

`ifdef LAYER_SCHED_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);
  logic signed [15:0] prod16;

  assign prod16 = act_data * w_data;
  assign prod   = {{(ACC_W-16){prod16[15]}}, prod16};
  assign bias   = {{(ACC_W-8){w_data[7]}}, w_data};
  assign acc8   = (acc_d > SAT_MAX) ? 8'h7f :
                  (acc_d < SAT_MIN) ? 8'h80 : acc_d[7:0];
`else
  // 8-bit context keeps only the low byte of the product, matching the legacy node.
  assign prod = act_data * w_data;
  assign bias = w_data;
  assign acc8 = acc_d;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    k_d        = k_q;
    act_addr_d = act_addr_q;
    w_addr_d   = w_addr_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    tag_vld_d  = (state_q == S_FETCH);
    tag_k_d    = k_q;
    acc_d      = acc_q;

    // Memory data lags the address by one cycle; the tag says which k it belongs to.
    if (tag_vld_q) begin
      if (tag_k_q == '0)          acc_d = prod;
      else if (tag_k_q == K_LAST) acc_d = acc_q + bias;
      else                        acc_d = acc_q + prod;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          n_d        = '0;
          k_d        = '0;
          act_addr_d = '0;
          w_addr_d   = '0;
        end
      end
      S_FETCH: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          k_d        = k_q + KW'(1);
          // The bias slot has no activation; the last activation address is simply held.
          act_addr_d = (k_d == K_LAST) ? act_addr_q : AW'(k_d);
          w_addr_d   = w_addr_q + WW'(1);
        end
      end
      S_DRAIN: begin
        out_data_d = acc8[7] ? 8'd0 : acc8;
        out_idx_d  = n_q;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (n_q == N_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_FETCH;
            n_d        = n_q + OW'(1);
            k_d        = '0;
            act_addr_d = '0;
            w_addr_d   = w_addr_q + WW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      k_q        <= '0;
      act_addr_q <= '0;
      w_addr_q   <= '0;
      tag_vld_q  <= 1'b0;
      tag_k_q    <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      act_addr_q <= act_addr_d;
      w_addr_q   <= w_addr_d;
      tag_vld_q  <= tag_vld_d;
      tag_k_q    <= tag_k_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
    end
  end

  assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN) || (state_q == S_OUT);
  assign done      = (state_q == S_DONE);
  assign out_valid = (state_q == S_OUT);
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign act_addr  = act_addr_q;
  assign w_addr    = w_addr_q;

endmodule

// File: tb/tb_layer_sched.sv
// Self-checking bench for layer_sched: synchronous memory models plus a plain-arithmetic neuron model.
module tb_layer_sched;
  localparam int N_IN  = 10;
  localparam int N_OUT = 2;
  localparam int AW    = 4;
  localparam int WW    = 8;
  localparam int OW    = 4;
  localparam int BOUND = 400;

  logic              clk = 1'b0;
  logic              reset, start, out_ready;
  logic              busy, done, out_valid;
  logic [AW-1:0]     act_addr;
  logic [WW-1:0]     w_addr;
  logic signed [7:0] act_data, w_data;
  logic [OW-1:0]     out_idx;
  logic [7:0]        out_data;

  logic signed [7:0] act_mem [16];
  logic signed [7:0] w_mem   [256];

  int checks = 0;
  int errors = 0;

  layer_sched #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW), .WW(WW), .OW(OW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .act_addr(act_addr), .act_data(act_data), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data for an address appears one cycle later.
  always @(posedge clk) begin
    act_data <= act_mem[act_addr];
    w_data   <= w_mem[w_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Neuron model: exact integer dot product plus bias, then the build's overflow rule and ReLU.
  function automatic logic [7:0] ref_out(input int n);
    int s;
    s = 0;
    for (int k = 0; k < N_IN; k++)
      s += int'(act_mem[k]) * int'(w_mem[n*(N_IN+1)+k]);
    s += int'(w_mem[n*(N_IN+1)+N_IN]);
`ifdef LAYER_SCHED_SAT_EN
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
`else
    s = s & 255;
    if (s >= 128) s -= 256;
`endif
    return (s < 0) ? 8'd0 : s[7:0];
  endfunction

  task automatic fill_const(input int a, input int w, input int b);
    for (int k = 0; k < N_IN; k++) act_mem[k] = 8'(a);
    for (int n = 0; n < N_OUT; n++) begin
      for (int k = 0; k < N_IN; k++) w_mem[n*(N_IN+1)+k] = 8'(w);
      w_mem[n*(N_IN+1)+N_IN] = 8'(b);
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < N_IN; k++) act_mem[k] = 8'($urandom);
    for (int i = 0; i < N_OUT*(N_IN+1); i++) w_mem[i] = 8'($urandom);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_idx !== '0 ||
        out_data !== '0 || act_addr !== '0 || w_addr !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b valid=%b idx=%0d data=%0d act_addr=%0d w_addr=%0d, all required 0",
               name, busy, done, out_valid, out_idx, out_data, act_addr, w_addr);
    end
  endtask

  // Runs one layer. exp_const >= 0 overrides the model with a fixed expected result.
  task automatic run_layer(input string name, input int ready_pct, input bit inject,
                           input bit timing, input int exp_const);
    int cyc, first_valid, done_cyc, got, dones;
    logic [7:0]    exp_data, held_data;
    logic [OW-1:0] held_idx;
    bit            stalled;
    first_valid = -1; done_cyc = -1; got = 0; dones = 0; stalled = 0;
    held_data = '0; held_idx = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    end
    while (dones == 0 && cyc < BOUND) begin
      if (done === 1'b1) begin
        dones = 1;
        done_cyc = cyc;
        start = 1'b0;
      end else begin
        if (out_valid === 1'b1) begin
          if (first_valid < 0) first_valid = cyc;
          if (stalled) begin
            checks++;
            if (out_data !== held_data || out_idx !== held_idx) begin
              errors++;
              $display("FAIL %s stall_stable: data %0d idx %0d, required %0d idx %0d",
                       name, out_data, out_idx, held_data, held_idx);
            end
          end
          out_ready = ($urandom_range(99) < ready_pct);
          if (out_ready) begin
            exp_data = (exp_const >= 0) ? 8'(exp_const) : ref_out(got);
            checks++;
            if (got >= N_OUT || out_idx !== OW'(got) || out_data !== exp_data) begin
              errors++;
              $display("FAIL %s result%0d: idx %0d data %0d, required idx %0d data %0d",
                       name, got, out_idx, out_data, got, exp_data);
            end
            got++;
            stalled = 0;
          end else begin
            stalled = 1;
            held_data = out_data;
            held_idx = out_idx;
          end
        end else begin
          if (stalled) begin
            checks++;
            errors++;
            $display("FAIL %s valid_dropped: out_valid %b without handshake, required 1", name, out_valid);
            stalled = 0;
          end
          out_ready = ($urandom_range(99) < ready_pct);
        end
        start = inject && busy && ($urandom_range(1) == 1);
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL %s done_seen: %0d done pulses within %0d cycles, required 1", name, dones, BOUND);
    end
    checks++;
    if (got != N_OUT) begin
      errors++;
      $display("FAIL %s result_count: got %0d results, required %0d", name, got, N_OUT);
    end
    if (timing) begin
      checks++;
      if (first_valid != N_IN + 3) begin
        errors++;
        $display("FAIL %s first_valid_cycle: got %0d required %0d", name, first_valid, N_IN + 3);
      end
      checks++;
      if (done_cyc != N_OUT*(N_IN+3) + 1) begin
        errors++;
        $display("FAIL %s done_cycle: got %0d required %0d", name, done_cyc, N_OUT*(N_IN+3) + 1);
      end
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after_done: busy %b done %b, required 0 0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) act_mem[i] = '0;
    for (int i = 0; i < 256; i++) w_mem[i] = '0;
    #12;
    check_all_zero("reset_state");
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_all_zero("idle_after_release");
  endtask

  task automatic test_basic();
    fill_const(1, 1, 0);
    run_layer("basic_ones", 100, 1'b0, 1'b1, 10);
  endtask

  task automatic test_relu_clamp();
    fill_const(1, -1, -6);
    run_layer("relu_clamp", 100, 1'b0, 1'b0, 0);
  endtask

  task automatic test_overflow();
    fill_const(4, 8, 0);
`ifdef LAYER_SCHED_SAT_EN
    run_layer("overflow_sat", 100, 1'b0, 1'b0, 127);
`else
    run_layer("overflow_wrap", 100, 1'b0, 1'b0, 64);
`endif
  endtask

  task automatic test_stall();
    logic [7:0] h_data;
    logic [OW-1:0] h_idx;
    logic [WW-1:0] h_w;
    int cnt;
    fill_random();
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    h_data = out_data; h_idx = out_idx; h_w = w_addr;
    checks++;
    if (out_valid !== 1'b1 || h_idx !== '0 || h_data !== ref_out(0)) begin
      errors++;
      $display("FAIL stall_first: valid %b idx %0d data %0d, required 1 idx 0 data %0d",
               out_valid, h_idx, h_data, ref_out(0));
    end
    repeat (5) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== h_data || out_idx !== h_idx || w_addr !== h_w) begin
        errors++;
        $display("FAIL stall_hold: valid %b data %0d idx %0d w_addr %0d, required 1 %0d %0d %0d",
                 out_valid, out_data, out_idx, w_addr, h_data, h_idx, h_w);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || w_addr !== WW'(N_IN + 1) || act_addr !== '0) begin
      errors++;
      $display("FAIL stall_resume: valid %b busy %b w_addr %0d act_addr %0d, required 0 1 %0d 0",
               out_valid, busy, w_addr, act_addr, N_IN + 1);
    end
    cnt = 0;
    while (done !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: done %b after %0d cycles, required 1", done, cnt);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    fill_random();
    run_layer("start_while_busy", 100, 1'b1, 1'b1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_layer("random", 40 + 20*r, (r == 1), 1'b0, -1);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    fill_random();
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    tick();
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1 || w_addr !== WW'(N_IN + 1 + 3)) begin
      errors++;
      $display("FAIL mid_fetch_position: busy %b w_addr %0d, required 1 %0d", busy, w_addr, N_IN + 4);
    end
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid_fetch");
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_all_zero("idle_after_mid_reset");
    run_layer("after_reset", 100, 1'b0, 1'b1, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu_clamp();
    test_overflow();
    test_stall();
    test_start_ignored();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
